// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the E-stage multiply/divide sequencing controller:
// md operation codes, md unit opsrc codes and controller state encodings.
package md_ctrl_pkg;

    typedef enum logic [3:0] {
        MDOP_NONE  = 4'd0,
        MDOP_MULT  = 4'd1,
        MDOP_MULTU = 4'd2,
        MDOP_DIV   = 4'd3,
        MDOP_DIVU  = 4'd4,
        MDOP_MFHI  = 4'd5,
        MDOP_MFLO  = 4'd6,
        MDOP_MTHI  = 4'd7,
        MDOP_MTLO  = 4'd8
    } md_op_e;

    localparam logic [1:0] ALU_MULT  = 2'd0;
    localparam logic [1:0] ALU_MULTU = 2'd1;
    localparam logic [1:0] ALU_DIV   = 2'd2;
    localparam logic [1:0] ALU_DIVU  = 2'd3;

    localparam logic [1:0] WSRC_NONE = 2'd0;
    localparam logic [1:0] WSRC_HI   = 2'd1;
    localparam logic [1:0] WSRC_LO   = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Ops that start the md unit (mult/multu/div/divu).
    function automatic logic is_md_arith(input logic [3:0] op);
        return (op >= MDOP_MULT) && (op <= MDOP_DIVU);
    endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// Latency counter mirroring the md unit: loads the op latency on issue,
// counts down while running, and flags the final cycle (count == 1).
module md_lat_cnt (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       i_clr,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_done
);

    logic [3:0] r_cnt;

    always_ff @(posedge Clk) begin
        if (Reset || i_clr)
            r_cnt <= 4'd0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec)
            r_cnt <= r_cnt - 4'd1;
    end

    assign o_done = (r_cnt == 4'd1);

endmodule

// File: rtl/md_ctrl.sv
// Sequencing controller for the E-stage md unit: decode, start/opsrc/wsrc,
// exact D-stage stall and flush forwarding. Define MD_STALL_STATS_EN for the stall-cycle counter.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        valid_E,
    input  logic [3:0]  md_op_E,
    input  logic        md_use_D,
    input  logic        exc_flush,
    input  logic        md_busy,
    output logic        md_start,
    output logic [1:0]  md_opsrc,
    output logic [1:0]  md_wsrc,
    output logic        md_exc,
    output logic        stall_D,
    output logic [31:0] md_stall_cnt
);

    md_state_e  r_state;
    md_state_e  w_state_nxt;
    logic       w_issue;
    logic       w_done;
    logic [3:0] w_lat;

    always_comb begin
        w_issue     = valid_E & is_md_arith(md_op_E) & (r_state == ST_IDLE) & ~exc_flush;
        md_opsrc    = ALU_MULT;
        md_wsrc     = WSRC_NONE;
        w_lat       = 4'(DIV_CYC);
        w_state_nxt = r_state;

        case (md_op_E)
            MDOP_MULT:  begin md_opsrc = ALU_MULT;  w_lat = 4'(MULT_CYC); end
            MDOP_MULTU: begin md_opsrc = ALU_MULTU; w_lat = 4'(MULT_CYC); end
            MDOP_DIV:   md_opsrc = ALU_DIV;
            MDOP_DIVU:  md_opsrc = ALU_DIVU;
            default:    ;
        endcase

        if (valid_E && !exc_flush) begin
            if (md_op_E == MDOP_MTHI)      md_wsrc = WSRC_HI;
            else if (md_op_E == MDOP_MTLO) md_wsrc = WSRC_LO;
        end

        // An arith op seen while RUN is ignored; stall_D keeps it out of E.
        if (exc_flush)
            w_state_nxt = ST_IDLE;
        else begin
            case (r_state)
                ST_IDLE: if (w_issue) w_state_nxt = ST_RUN;
                ST_RUN:  if (w_done)  w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    md_lat_cnt u_cnt (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_clr      (exc_flush),
        .i_load     (w_issue),
        .i_load_val (w_lat),
        .i_dec      (r_state == ST_RUN),
        .o_done     (w_done)
    );

    assign md_start = w_issue;
    assign md_exc   = exc_flush;
    assign stall_D  = md_use_D & ~exc_flush & (w_issue | (r_state == ST_RUN) | md_busy);

`ifdef MD_STALL_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge Clk) begin
        if (Reset)        r_stall_cnt <= 32'd0;
        else if (stall_D) r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign md_stall_cnt = r_stall_cnt;
`else
    assign md_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_md_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, valid_E, md_use_D, exc_flush, md_busy;
    logic [3:0]  md_op_E;
    logic        md_start, md_exc, stall_D;
    logic [1:0]  md_opsrc, md_wsrc;
    logic [31:0] md_stall_cnt;

    always #5 Clk = ~Clk;

    md_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .Clk(Clk), .Reset(Reset), .valid_E(valid_E), .md_op_E(md_op_E),
        .md_use_D(md_use_D), .exc_flush(exc_flush), .md_busy(md_busy),
        .md_start(md_start), .md_opsrc(md_opsrc), .md_wsrc(md_wsrc),
        .md_exc(md_exc), .stall_D(stall_D), .md_stall_cnt(md_stall_cnt)
    );

    typedef struct packed {
        logic [15:0] id;
        logic        start;
        logic [1:0]  opsrc;
        logic [1:0]  wsrc;
        logic        exc;
        logic        stall;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   n_push = 0;
    logic [31:0] exp_cnt = 32'd0;

    // Monitor: outputs are settled mid-cycle, compare one vector per cycle.
    always @(negedge Clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if ({md_start, md_opsrc, md_wsrc, md_exc, stall_D, md_stall_cnt} !==
                {e.start, e.opsrc, e.wsrc, e.exc, e.stall, e.cnt}) begin
                n_fail++;
                $display("FAIL vec%0d: got start=%b opsrc=%0d wsrc=%0d exc=%b stall=%b cnt=%0d, want start=%b opsrc=%0d wsrc=%0d exc=%b stall=%b cnt=%0d",
                         e.id, md_start, md_opsrc, md_wsrc, md_exc, stall_D, md_stall_cnt,
                         e.start, e.opsrc, e.wsrc, e.exc, e.stall, e.cnt);
            end
        end
    end

    // One cycle of stimulus plus its hand-computed expected outputs.
    task automatic v(input logic rst, input logic vld, input logic [3:0] op,
                     input logic use_d, input logic fl, input logic busy,
                     input logic x_start, input logic [1:0] x_opsrc,
                     input logic [1:0] x_wsrc, input logic x_stall);
        exp_t e;
        @(posedge Clk);
        #1;
        Reset = rst; valid_E = vld; md_op_E = op;
        md_use_D = use_d; exc_flush = fl; md_busy = busy;
        e.id    = 16'(n_push);
        e.start = x_start;
        e.opsrc = x_opsrc;
        e.wsrc  = x_wsrc;
        e.exc   = fl;
        e.stall = x_stall;
`ifdef MD_STALL_STATS_EN
        e.cnt = exp_cnt;
        if (rst)          exp_cnt = 32'd0;
        else if (x_stall) exp_cnt = exp_cnt + 32'd1;
`else
        e.cnt = 32'd0;
`endif
        sb.push_back(e);
        n_push++;
    endtask

    initial begin
        Reset = 1'b1; valid_E = 1'b0; md_op_E = 4'd0;
        md_use_D = 1'b0; exc_flush = 1'b0; md_busy = 1'b0;
        repeat (2) @(posedge Clk);

        // Reset state, all outputs idle
        v(1, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        // mult in E, mfhi in D: 6 stall cycles, then D advances
        v(0, 1, 1, 1, 0, 0,  1, 0, 0, 1);
        repeat (5) v(0, 0, 0, 1, 0, 0,  0, 0, 0, 1);
        v(0, 0, 0, 1, 0, 0,  0, 0, 0, 0);
        v(0, 1, 5, 0, 0, 0,  0, 0, 0, 0);
        // Stats counter (6 when enabled) cleared by Reset
        v(1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        // mthi/mtlo while idle, flushed mthi, op 12 as none, invalid mtlo
        v(0, 1, 7,  0, 0, 0,  0, 0, 1, 0);
        v(0, 1, 8,  1, 0, 0,  0, 0, 2, 0);
        v(0, 1, 7,  0, 1, 0,  0, 0, 0, 0);
        v(0, 1, 12, 1, 0, 0,  0, 0, 0, 0);
        v(0, 0, 8,  0, 0, 0,  0, 0, 0, 0);

        // div with D idle: a divu held in E is refused for exactly 10 cycles
        v(0, 1, 3, 0, 0, 0,  1, 2, 0, 0);
        repeat (10) v(0, 1, 4, 0, 0, 0,  0, 3, 0, 0);
        v(0, 1, 4, 0, 0, 0,  1, 3, 0, 0);
        repeat (10) v(0, 0, 0, 1, 0, 1,  0, 0, 0, 1);
        v(0, 0, 0, 1, 0, 0,  0, 0, 0, 0);

        // Flush in the issue cycle: no start, controller stays idle
        v(0, 1, 2, 1, 1, 0,  0, 1, 0, 0);
        v(0, 1, 8, 1, 0, 0,  0, 0, 2, 0);

        // Flush mid-div, then a normal mult and a back-to-back multu
        v(0, 1, 3, 1, 0, 0,  1, 2, 0, 1);
        repeat (3) v(0, 0, 0, 1, 0, 0,  0, 0, 0, 1);
        v(0, 0, 0, 1, 1, 0,  0, 0, 0, 0);
        v(0, 1, 1, 1, 0, 0,  1, 0, 0, 1);
        repeat (5) v(0, 0, 0, 1, 0, 0,  0, 0, 0, 1);
        v(0, 1, 2, 1, 0, 0,  1, 1, 0, 1);
        repeat (5) v(0, 0, 0, 1, 0, 0,  0, 0, 0, 1);
        v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge Clk);
        #1;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d vectors left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
